// File: rtl/smac_pkg.sv
// Shared types and sizing helpers for the bit-serial weight-plane accumulator.
// Optional feature macro: SMAC_SIGNED_WEIGHT_EN (two's complement weights).
package smac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2
  } acc_state_t;

  // Width of the signed running value driven to the AC2 shift register.
  function automatic int acc_w(input int m, input int pa);
    return $clog2(m) + pa + 1;
  endfunction

endpackage

// File: rtl/ac2_plane_sum.sv
// Combinational masked lane adder: sums every activation whose weight bit is set.
// Result is zero-extended to $clog2(M)+PA bits, wide enough for M full-scale lanes.
module ac2_plane_sum
  import smac_pkg::*;
#(
  parameter int M  = 16,
  parameter int PA = 8,
  parameter int SW = acc_w(M, PA) - 1
) (
  input  logic [M*PA-1:0] act_in,
  input  logic [M-1:0]    wbit_in,
  output logic [SW-1:0]   sum
);

  // Masked sum of all lanes for the current weight bit-plane.
  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) begin
      if (wbit_in[i]) begin
        sum = sum + SW'(act_in[i*PA +: PA]);
      end
    end
  end

endmodule

// File: rtl/ac2_plane_acc.sv
// Bit-serial weight-plane accumulator feeding the AC2 shift register.
// Each accepted plane k produces r_k = s_k + (r_{k-1} >>> 1), LSB plane first.
// Optional feature macro: SMAC_SIGNED_WEIGHT_EN -- the last plane (weight sign
// bit) is subtracted instead of added.
//
// Handshake: a plane is transferred on a rising clk edge where
// plane_valid & plane_ready are both high; plane_valid may be dropped at any
// time (gaps), plane_ready is high for the whole ACCUM state and low otherwise.
module ac2_plane_acc
  import smac_pkg::*;
#(
  parameter int M  = 16,
  parameter int PA = 8,
  parameter int PW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       plane_valid,
  output logic                       plane_ready,
  input  logic [M*PA-1:0]            act_in,
  input  logic [M-1:0]               wbit_in,
  output logic signed [acc_w(M,PA)-1:0] ac2_out,
  output logic                       w_and_s,
  output logic                       cl_en,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = acc_w(M, PA);
  localparam int SW = AW - 1;
  localparam int KW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_ACCUM = ACCUM;

  logic [1:0]           state;
  logic [KW-1:0]        k;
  // Running value kept one bit wider than the port: intermediate sums of
  // positive planes approach 2*s_max, which only fits AW bits unsigned. The
  // downstream concatenation uses the dropped LSBs and the final value, both
  // of which are exact in the low AW bits.
  logic signed [AW:0]   acc;
  logic signed [AW:0]   acc_half;
  logic signed [AW:0]   s_ext;
  logic signed [AW:0]   acc_next;
  logic [SW-1:0]        s_k;
  logic                 accept;
  logic                 last_plane;

  ac2_plane_sum #(
    .M  (M),
    .PA (PA),
    .SW (SW)
  ) u_sum (
    .act_in  (act_in),
    .wbit_in (wbit_in),
    .sum     (s_k)
  );

  assign plane_ready = (state == ST_ACCUM);
  assign cl_en       = (state == ST_CLEAR);
  assign busy        = (state != ST_IDLE);
  assign accept      = plane_valid & plane_ready;
  assign last_plane  = (k == KW'(PW - 1));
  assign ac2_out     = acc[AW-1:0];

  // Next running value: halve the previous result (zero for plane 0) and add
  // or, for the sign plane of signed weights, subtract the masked lane sum.
  always_comb begin
    s_ext    = $signed({2'b00, s_k});
    acc_half = '0;
    if (k != '0) begin
      acc_half = acc >>> 1;
    end
`ifdef SMAC_SIGNED_WEIGHT_EN
    if (last_plane) begin
      acc_next = acc_half - s_ext;
    end else begin
      acc_next = acc_half + s_ext;
    end
`else
    acc_next = acc_half + s_ext;
`endif
  end

  // Control FSM, plane counter, running register and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      acc     <= '0;
      w_and_s <= 1'b0;
      done    <= 1'b0;
    end else begin
      w_and_s <= accept;
      done    <= accept & last_plane;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          k     <= '0;
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            if (last_plane) begin
              k     <= '0;
              state <= ST_IDLE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
